// File: rtl/csr_issue_buffer_pkg.sv
// Shared core definitions for the CSR issue stage.
//   - datapath widths used on the RCU -> csr path
//   - csr_issue_entry_t : one buffered CSR instruction
//   - csr_issue_state_e : issue FSM state encoding
package csr_issue_buffer_pkg;

    localparam int ROB_INDEX_WIDTH    = 6;
    localparam int PHY_REG_ADDR_WIDTH = 6;
    localparam int XLEN               = 64;
    localparam int CSR_ADDR_LEN       = 12;
    localparam int IMM_LEN            = 5;

    typedef struct packed {
        logic [ROB_INDEX_WIDTH-1:0]    rob_index;
        logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr;
        logic [2:0]                    func3;
        logic [XLEN-1:0]               rs1;
        logic [IMM_LEN-1:0]            imm;
        logic [CSR_ADDR_LEN-1:0]       csr_addr;
        logic                          do_read;
        logic                          do_write;
    } csr_issue_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HEAD,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_DRAIN
    } csr_issue_state_e;

endpackage

// File: rtl/csr_issue_buffer_if.sv
// Handshake/payload bundle between RCU, the CSR issue buffer and the csr unit.
//   slave  : the issue buffer (consumes *_i, drives *_o)
//   master : the surrounding pipeline (drives *_i, observes *_o)
interface csr_issue_buffer_if;
    import csr_issue_buffer_pkg::*;

    logic                          rcu_csr_issue_valid_i;
    logic                          csr_issue_rcu_ready_o;
    logic [ROB_INDEX_WIDTH-1:0]    rob_index_i;
    logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_i;
    logic [2:0]                    func3_i;
    logic [XLEN-1:0]               prs1_data_i;
    logic [IMM_LEN-1:0]            imm_i;
    logic [CSR_ADDR_LEN-1:0]       csr_addr_i;
    logic                          csr_do_read_i;
    logic                          csr_do_write_i;
    logic [ROB_INDEX_WIDTH-1:0]    rob_head_index_i;
    logic                          flush_i;
    logic                          rcu_csr_req_valid_o;
    logic [ROB_INDEX_WIDTH-1:0]    rob_index_o;
    logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_o;
    logic [2:0]                    func3_o;
    logic [XLEN-1:0]               prs1_data_o;
    logic [IMM_LEN-1:0]            imm_o;
    logic [CSR_ADDR_LEN-1:0]       csr_addr_o;
    logic                          csr_do_read_o;
    logic                          csr_do_write_o;
    logic                          csr_rcu_resp_valid_i;
    logic                          resp_drop_o;
    logic                          csr_busy_o;
    logic                          csr_timeout_o;

    modport slave (
        input  rcu_csr_issue_valid_i, rob_index_i, prd_addr_i, func3_i, prs1_data_i,
               imm_i, csr_addr_i, csr_do_read_i, csr_do_write_i, rob_head_index_i,
               flush_i, csr_rcu_resp_valid_i,
        output csr_issue_rcu_ready_o, rcu_csr_req_valid_o, rob_index_o, prd_addr_o,
               func3_o, prs1_data_o, imm_o, csr_addr_o, csr_do_read_o, csr_do_write_o,
               resp_drop_o, csr_busy_o, csr_timeout_o
    );

    modport master (
        output rcu_csr_issue_valid_i, rob_index_i, prd_addr_i, func3_i, prs1_data_i,
               imm_i, csr_addr_i, csr_do_read_i, csr_do_write_i, rob_head_index_i,
               flush_i, csr_rcu_resp_valid_i,
        input  csr_issue_rcu_ready_o, rcu_csr_req_valid_o, rob_index_o, prd_addr_o,
               func3_o, prs1_data_o, imm_o, csr_addr_o, csr_do_read_o, csr_do_write_o,
               resp_drop_o, csr_busy_o, csr_timeout_o
    );

endinterface

// File: rtl/csr_issue_buffer_fifo.sv
// csr_issue_fifo: in-order synchronous FIFO of csr_issue_entry_t.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write one entry (ignored when full without pop, or on flush)
//   pop               retire the head entry (ignored when empty)
//   flush             discard all entries
//   head_data         current head entry, all-zero when empty
//   full, empty       occupancy flags
//   count             number of stored entries
module csr_issue_fifo
    import csr_issue_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  csr_issue_entry_t       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output csr_issue_entry_t       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    csr_issue_entry_t mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/csr_issue_buffer.sv
// csr_issue_buffer: serialising issue stage in front of the csr unit.
// Buffers CSR ops from RCU in order, issues the head as a one-cycle request once
// its ROB index reaches the ROB head, and keeps a single request outstanding.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        csr_issue_buffer_if.slave (RCU enqueue, csr request/response,
//              flush, drop/busy/timeout status)
// Optional build macro: CSR_ISSUE_TIMEOUT_EN adds a WAIT_RESP watchdog that
// gives up after TIMEOUT_CYCLES, pulses csr_timeout_o and discards the head.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | nothing issuable yet; leaves as soon as the FIFO has an entry
// ST_WAIT_HEAD | head entry waits for its ROB index to become the ROB head
// ST_ISSUE     | one-cycle request to csr for the head entry
// ST_WAIT_RESP | request outstanding; head popped on response
// ST_DRAIN     | flushed while outstanding; the late response is dropped
module csr_issue_buffer
    import csr_issue_buffer_pkg::*;
#(
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    csr_issue_buffer_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE = 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("csr_issue_buffer: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
        $error("csr_issue_buffer: TIMEOUT_CYCLES must be >= 1");
    end

    csr_issue_state_e state_q, state_d;
    csr_issue_entry_t push_entry;
    csr_issue_entry_t head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic             ready;
    logic             push;
    logic             pop;
    logic             resp_pop;
    logic             timeout_pop;
    logic             req_valid;
    logic             resp_drop;

    always_comb begin
        push_entry          = '0;
        push_entry.rob_index = bus.rob_index_i;
        push_entry.prd_addr  = bus.prd_addr_i;
        push_entry.func3     = bus.func3_i;
        push_entry.rs1       = bus.prs1_data_i;
        push_entry.imm       = bus.imm_i;
        push_entry.csr_addr  = bus.csr_addr_i;
        push_entry.do_read   = bus.csr_do_read_i;
        push_entry.do_write  = bus.csr_do_write_i;
    end

    // Popping only happens in WAIT_RESP, so a full FIFO accepts a new entry
    // only in the cycle the outstanding op completes (or times out).
    assign resp_pop = (state_q == ST_WAIT_RESP) && bus.csr_rcu_resp_valid_i && !bus.flush_i;
    assign pop      = resp_pop || timeout_pop;
    assign ready    = !rst && (state_q != ST_DRAIN) && (!fifo_full || pop);
    assign push     = bus.rcu_csr_issue_valid_i && ready && !bus.flush_i;

    csr_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.flush_i),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        resp_drop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.flush_i && !fifo_empty) state_d = ST_WAIT_HEAD;
            end
            ST_WAIT_HEAD: begin
                if (bus.flush_i)                              state_d = ST_IDLE;
                else if (head.rob_index == bus.rob_head_index_i) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    req_valid = 1'b1;
                    state_d   = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (bus.flush_i) begin
                    // A response landing with the flush already belongs to the
                    // flushed op; drop it now rather than waiting in DRAIN for
                    // one that never comes.
                    if (bus.csr_rcu_resp_valid_i) begin
                        resp_drop = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (resp_pop) begin
                    state_d = (fifo_count > CNT_ONE || push) ? ST_WAIT_HEAD : ST_IDLE;
                end else if (timeout_pop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.csr_rcu_resp_valid_i) begin
                    resp_drop = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef CSR_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_ONE  = 1;

    logic [TW-1:0] tmr_q;

    // Down-counter loaded on entry; terminal count in WAIT_RESP means
    // TIMEOUT_CYCLES full cycles passed without a response.
    always_ff @(posedge clk) begin
        if (rst)                          tmr_q <= '0;
        else if (state_d != ST_WAIT_RESP) tmr_q <= '0;
        else if (state_q != ST_WAIT_RESP) tmr_q <= TMR_LOAD;
        else if (tmr_q != '0)             tmr_q <= tmr_q - TMR_ONE;
    end

    assign timeout_pop = (state_q == ST_WAIT_RESP) && !bus.csr_rcu_resp_valid_i &&
                         !bus.flush_i && (tmr_q == '0);
    assign bus.csr_timeout_o = timeout_pop;
`else
    assign timeout_pop       = 1'b0;
    assign bus.csr_timeout_o = 1'b0;
`endif

    assign bus.csr_issue_rcu_ready_o = ready;
    assign bus.rcu_csr_req_valid_o   = req_valid;
    assign bus.resp_drop_o           = resp_drop;
    assign bus.csr_busy_o            = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.rob_index_o           = head.rob_index;
    assign bus.prd_addr_o            = head.prd_addr;
    assign bus.func3_o               = head.func3;
    assign bus.prs1_data_o           = head.rs1;
    assign bus.imm_o                 = head.imm;
    assign bus.csr_addr_o            = head.csr_addr;
    assign bus.csr_do_read_o         = head.do_read;
    assign bus.csr_do_write_o        = head.do_write;

endmodule

// File: tb/tb_csr_issue_buffer.sv
// Directed testbench for csr_issue_buffer (DEPTH=2, TIMEOUT_CYCLES=8).
module tb_csr_issue_buffer;
    import csr_issue_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    csr_issue_buffer_if bus ();

    csr_issue_buffer #(.DEPTH(2), .TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_op(input logic [5:0] rob, input logic [11:0] addr, input logic [63:0] rs1);
        bus.rcu_csr_issue_valid_i = 1'b1;
        bus.rob_index_i           = rob;
        bus.prd_addr_i            = rob + 6'd1;
        bus.func3_i               = 3'b001;
        bus.prs1_data_i           = rs1;
        bus.imm_i                 = 5'h0A;
        bus.csr_addr_i            = addr;
        bus.csr_do_read_i         = 1'b1;
        bus.csr_do_write_i        = 1'b1;
    endtask

    initial begin
        bus.rcu_csr_issue_valid_i = 1'b0;
        bus.rob_index_i           = '0;
        bus.prd_addr_i            = '0;
        bus.func3_i               = '0;
        bus.prs1_data_i           = '0;
        bus.imm_i                 = '0;
        bus.csr_addr_i            = '0;
        bus.csr_do_read_i         = 1'b0;
        bus.csr_do_write_i        = 1'b0;
        bus.rob_head_index_i      = '0;
        bus.flush_i               = 1'b0;
        bus.csr_rcu_resp_valid_i  = 1'b0;

        // reset
        tick(); tick();
        check_val("rst_ready",   64'(bus.csr_issue_rcu_ready_o), 64'd0);
        check_val("rst_req",     64'(bus.rcu_csr_req_valid_o),   64'd0);
        check_val("rst_busy",    64'(bus.csr_busy_o),            64'd0);
        check_val("rst_drop",    64'(bus.resp_drop_o),           64'd0);
        check_val("rst_timeout", 64'(bus.csr_timeout_o),         64'd0);
        check_val("rst_rob",     64'(bus.rob_index_o),           64'd0);
        rst = 1'b0;
        settle();
        check_val("post_rst_ready", 64'(bus.csr_issue_rcu_ready_o), 64'd1);

        // single op: CSRRW 0x180, rob 5 with head already 5
        bus.rob_head_index_i = 6'd5;
        drive_op(6'd5, 12'h180, 64'h8F0F0F0F0F0F0F0F);
        settle();
        tick();
        bus.rcu_csr_issue_valid_i = 1'b0;
        settle();
        check_val("s_req_c1",  64'(bus.rcu_csr_req_valid_o), 64'd0);
        check_val("s_busy_c1", 64'(bus.csr_busy_o),          64'd1);
        tick();
        check_val("s_req_c2",  64'(bus.rcu_csr_req_valid_o), 64'd0);
        tick();
        check_val("s_req_c3",  64'(bus.rcu_csr_req_valid_o), 64'd1);
        check_val("s_rob",     64'(bus.rob_index_o),         64'd5);
        check_val("s_prd",     64'(bus.prd_addr_o),          64'd6);
        check_val("s_addr",    64'(bus.csr_addr_o),          64'h180);
        check_val("s_rs1",     bus.prs1_data_o,              64'h8F0F0F0F0F0F0F0F);
        check_val("s_func3",   64'(bus.func3_o),             64'd1);
        check_val("s_imm",     64'(bus.imm_o),               64'h0A);
        check_val("s_wr",      64'(bus.csr_do_write_o),      64'd1);
        tick();
        check_val("s_req_c4",  64'(bus.rcu_csr_req_valid_o), 64'd0);
        tick();
        bus.csr_rcu_resp_valid_i = 1'b1;
        settle();
        check_val("s_drop",    64'(bus.resp_drop_o),         64'd0);
        tick();
        bus.csr_rcu_resp_valid_i = 1'b0;
        settle();
        check_val("s_busy_end", 64'(bus.csr_busy_o),         64'd0);
        check_val("s_rob_empty", 64'(bus.rob_index_o),       64'd0);

        // head gating: rob 7 waits while head = 4; stray response ignored
        bus.rob_head_index_i = 6'd4;
        drive_op(6'd7, 12'h305, 64'h1234);
        tick();
        bus.rcu_csr_issue_valid_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus.csr_rcu_resp_valid_i = (i == 5);
            settle();
            check_val("hg_wait_req", 64'(bus.rcu_csr_req_valid_o), 64'd0);
            if (i == 6) check_val("hg_stray_resp_kept", 64'(bus.rob_index_o), 64'd7);
            if (i == 5) check_val("hg_stray_drop", 64'(bus.resp_drop_o), 64'd0);
            tick();
        end
        bus.csr_rcu_resp_valid_i = 1'b0;
        bus.rob_head_index_i = 6'd7;
        settle();
        check_val("hg_match_req", 64'(bus.rcu_csr_req_valid_o), 64'd0);
        tick();
        check_val("hg_issue_req", 64'(bus.rcu_csr_req_valid_o), 64'd1);
        check_val("hg_issue_rob", 64'(bus.rob_index_o),         64'd7);
        tick();
        bus.csr_rcu_resp_valid_i = 1'b1;
        tick();
        bus.csr_rcu_resp_valid_i = 1'b0;
        settle();
        check_val("hg_busy_end", 64'(bus.csr_busy_o), 64'd0);

        // back-pressure with three ops into a 2-deep FIFO
        bus.rob_head_index_i = 6'd8;
        drive_op(6'd8, 12'h300, 64'hA);
        settle();
        check_val("bp_rdy0", 64'(bus.csr_issue_rcu_ready_o), 64'd1);
        tick();
        drive_op(6'd9, 12'h341, 64'hB);
        settle();
        check_val("bp_rdy1", 64'(bus.csr_issue_rcu_ready_o), 64'd1);
        tick();
        drive_op(6'd10, 12'h141, 64'hC);
        settle();
        check_val("bp_full", 64'(bus.csr_issue_rcu_ready_o), 64'd0);
        tick();
        check_val("bp_full_issue", 64'(bus.csr_issue_rcu_ready_o), 64'd0);
        check_val("bp_req_a",      64'(bus.rcu_csr_req_valid_o),   64'd1);
        check_val("bp_addr_a",     64'(bus.csr_addr_o),            64'h300);
        tick();
        for (int i = 0; i < 3; i++) begin
            check_val("bp_hold_req", 64'(bus.rcu_csr_req_valid_o),   64'd0);
            check_val("bp_hold_rdy", 64'(bus.csr_issue_rcu_ready_o), 64'd0);
            tick();
        end
        bus.csr_rcu_resp_valid_i = 1'b1;
        bus.rob_head_index_i     = 6'd9;
        settle();
        check_val("bp_pop_push_rdy", 64'(bus.csr_issue_rcu_ready_o), 64'd1);
        tick();
        bus.csr_rcu_resp_valid_i  = 1'b0;
        bus.rcu_csr_issue_valid_i = 1'b0;
        settle();
        check_val("bp_gap_req", 64'(bus.rcu_csr_req_valid_o), 64'd0);
        check_val("bp_head_b",  64'(bus.rob_index_o),         64'd9);
        tick();
        check_val("bp_req_b",   64'(bus.rcu_csr_req_valid_o), 64'd1);
        check_val("bp_addr_b",  64'(bus.csr_addr_o),          64'h341);
        tick();
        bus.csr_rcu_resp_valid_i = 1'b1;
        bus.rob_head_index_i     = 6'd10;
        tick();
        bus.csr_rcu_resp_valid_i = 1'b0;
        settle();
        check_val("bp_gap_req2", 64'(bus.rcu_csr_req_valid_o), 64'd0);
        check_val("bp_head_c",   64'(bus.rob_index_o),         64'd10);
        tick();
        check_val("bp_req_c",    64'(bus.rcu_csr_req_valid_o), 64'd1);
        check_val("bp_addr_c",   64'(bus.csr_addr_o),          64'h141);
        tick();
        bus.csr_rcu_resp_valid_i = 1'b1;
        tick();
        bus.csr_rcu_resp_valid_i = 1'b0;
        settle();
        check_val("bp_busy_end", 64'(bus.csr_busy_o), 64'd0);

        // flush while waiting for the response
        bus.rob_head_index_i = 6'd11;
        drive_op(6'd11, 12'h300, 64'h5);
        tick();
        bus.rcu_csr_issue_valid_i = 1'b0;
        tick(); tick();
        check_val("fw_req", 64'(bus.rcu_csr_req_valid_o), 64'd1);
        tick();
        drive_op(6'd12, 12'h340, 64'h6);
        bus.rob_head_index_i = 6'd12;
        tick();
        drive_op(6'd13, 12'h342, 64'h7);
        bus.flush_i = 1'b1;
        settle();
        check_val("fw_flush_req", 64'(bus.rcu_csr_req_valid_o), 64'd0);
        tick();
        bus.flush_i               = 1'b0;
        bus.rcu_csr_issue_valid_i = 1'b0;
        settle();
        check_val("fw_drain_rdy",  64'(bus.csr_issue_rcu_ready_o), 64'd0);
        check_val("fw_drain_busy", 64'(bus.csr_busy_o),            64'd1);
        check_val("fw_fifo_empty", 64'(bus.rob_index_o),           64'd0);
        tick();
        check_val("fw_drain_req",  64'(bus.rcu_csr_req_valid_o),   64'd0);
        tick();
        bus.csr_rcu_resp_valid_i = 1'b1;
        settle();
        check_val("fw_drop", 64'(bus.resp_drop_o), 64'd1);
        tick();
        bus.csr_rcu_resp_valid_i = 1'b0;
        settle();
        check_val("fw_drop_off", 64'(bus.resp_drop_o), 64'd0);
        check_val("fw_busy_end", 64'(bus.csr_busy_o),  64'd0);
        for (int i = 0; i < 4; i++) begin
            check_val("fw_no_req", 64'(bus.rcu_csr_req_valid_o), 64'd0);
            tick();
        end

        // flush coincident with ISSUE
        bus.rob_head_index_i = 6'd14;
        drive_op(6'd14, 12'h342, 64'h9);
        tick();
        bus.rcu_csr_issue_valid_i = 1'b0;
        tick(); tick();
        bus.flush_i = 1'b1;
        settle();
        check_val("fi_req", 64'(bus.rcu_csr_req_valid_o), 64'd0);
        tick();
        bus.flush_i = 1'b0;
        settle();
        check_val("fi_busy", 64'(bus.csr_busy_o),          64'd0);
        check_val("fi_req2", 64'(bus.rcu_csr_req_valid_o), 64'd0);
        tick();
        check_val("fi_req3", 64'(bus.rcu_csr_req_valid_o), 64'd0);

        // watchdog
        bus.rob_head_index_i = 6'd15;
        drive_op(6'd15, 12'h343, 64'hF);
        tick();
        bus.rcu_csr_issue_valid_i = 1'b0;
        tick(); tick();
        check_val("to_req", 64'(bus.rcu_csr_req_valid_o), 64'd1);
        tick();
`ifdef CSR_ISSUE_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check_val("to_quiet", 64'(bus.csr_timeout_o), 64'd0);
            tick();
        end
        check_val("to_pulse",      64'(bus.csr_timeout_o), 64'd1);
        check_val("to_busy_pulse", 64'(bus.csr_busy_o),    64'd1);
        tick();
        check_val("to_pulse_off",  64'(bus.csr_timeout_o), 64'd0);
        check_val("to_idle",       64'(bus.csr_busy_o),    64'd0);
`else
        for (int i = 0; i < 12; i++) begin
            check_val("to_off",  64'(bus.csr_timeout_o), 64'd0);
            check_val("to_wait", 64'(bus.csr_busy_o),    64'd1);
            tick();
        end
        bus.csr_rcu_resp_valid_i = 1'b1;
        tick();
        bus.csr_rcu_resp_valid_i = 1'b0;
        settle();
        check_val("to_idle", 64'(bus.csr_busy_o), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
